// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war match sequencer.
// The state_t encoding doubles as the externally visible phase value.
package tug_pkg;

  localparam int SCORE_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    OVER  = 3'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b10;
  localparam logic [1:0] WIN_R    = 2'b01;

  // Increment that never passes the match limit.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/tug_match_ctrl_pause_timer.sv
// Between-rounds down-counter: load sets CYCLES-1, done flags a zero count.
// The counter sits at zero outside a pause, so done is only meaningful in PAUSE.
module pause_timer #(
  parameter int CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LOAD_VAL;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tug_match_ctrl.sv
// Match sequencer: gates presses while a round is live, scores round wins
// from the playfield edge LEDs, pauses between rounds and declares a winner.
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int WIN_ROUNDS   = 7,
  parameter int PAUSE_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               p_l,
  input  logic               p_r,
  input  logic               l_edge,
  input  logic               r_edge,
  output logic               l_gate,
  output logic               r_gate,
  output logic               field_clr,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         winner,
  output logic [2:0]         phase
);

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_ROUNDS);

  state_t             state_d, state_q;
  logic [SCORE_W-1:0] score_l_d, score_l_q;
  logic [SCORE_W-1:0] score_r_d, score_r_q;
  logic [1:0]         winner_d, winner_q;
  logic               field_clr_d, field_clr_q;
  logic               pause_load, pause_done;
  logic               l_win, r_win;

  pause_timer #(.CYCLES(PAUSE_CYCLES)) u_pause_timer (
    .clk  (clk),
    .rst  (rst),
    .load (pause_load),
    .done (pause_done)
  );

  // A simultaneous press from both sides never scores.
  assign l_win = l_edge & p_l & ~p_r;
  assign r_win = r_edge & p_r & ~p_l;

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    field_clr_d = 1'b0;
    pause_load  = 1'b0;

    if (start) begin
      state_d     = PLAY;
      score_l_d   = '0;
      score_r_d   = '0;
      winner_d    = WIN_NONE;
      field_clr_d = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (l_win) begin
            score_l_d = sat_inc(score_l_q, WIN_S);
            if (score_l_d == WIN_S) begin
              state_d  = OVER;
              winner_d = WIN_L;
            end else begin
              state_d     = PAUSE;
              field_clr_d = 1'b1;
              pause_load  = 1'b1;
            end
          end else if (r_win) begin
            score_r_d = sat_inc(score_r_q, WIN_S);
            if (score_r_d == WIN_S) begin
              state_d  = OVER;
              winner_d = WIN_R;
            end else begin
              state_d     = PAUSE;
              field_clr_d = 1'b1;
              pause_load  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (pause_done) state_d = PLAY;
        end
        IDLE, OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      field_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      field_clr_q <= field_clr_d;
    end
  end

  assign l_gate    = p_l & (state_q == PLAY);
  assign r_gate    = p_r & (state_q == PLAY);
  assign field_clr = field_clr_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign winner    = winner_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Bench for tug_match_ctrl with WIN_ROUNDS=3, PAUSE_CYCLES=4: vector table
// with expected registered outputs queued per cycle, plus an async-reset sequence.
module tb_tug_match_ctrl;
  import tug_pkg::*;

  localparam int WR = 3;
  localparam int PC = 4;

  logic       clk, rst, start, p_l, p_r, l_edge, r_edge;
  logic       l_gate, r_gate, field_clr;
  logic [2:0] score_l, score_r, phase;
  logic [1:0] winner;

  tug_match_ctrl #(.WIN_ROUNDS(WR), .PAUSE_CYCLES(PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p_l       (p_l),
    .p_r       (p_r),
    .l_edge    (l_edge),
    .r_edge    (r_edge),
    .l_gate    (l_gate),
    .r_gate    (r_gate),
    .field_clr (field_clr),
    .score_l   (score_l),
    .score_r   (score_r),
    .winner    (winner),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       st, pl, pr, le, re;
    logic       lg, rg, fc;
    logic [2:0] sl, sr;
    logic [1:0] win;
    logic [2:0] ph;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic st, pl, pr, le, re, lg, rg, fc,
                     input logic [2:0] sl, sr, input logic [1:0] win, input state_t ph);
    vec_t v;
    v.name = nm; v.st = st; v.pl = pl; v.pr = pr; v.le = le; v.re = re;
    v.lg = lg; v.rg = rg; v.fc = fc; v.sl = sl; v.sr = sr; v.win = win; v.ph = ph;
    vecs.push_back(v);
  endtask

  // Quiet cycles filling the rest of a pause; the last one lands back in PLAY.
  task automatic add_pause(input logic [2:0] sl, sr);
    for (int k = 0; k < PC - 1; k++) add("pause_wait", 0,0,0,0,0, 0,0, 0, sl, sr, WIN_NONE, PAUSE);
    add("pause_end", 0,0,0,0,0, 0,0, 0, sl, sr, WIN_NONE, PLAY);
  endtask

  initial begin
    vec_t v, e;
    rst = 1'b0; start = 0; p_l = 0; p_r = 0; l_edge = 0; r_edge = 0;

    //   name            st pl pr le re  lg rg fc sl sr win       phase
    add("idle_press",    0, 1, 1, 0, 0,  0, 0, 0, 0, 0, WIN_NONE, IDLE);
    add("idle_edge",     0, 1, 0, 1, 0,  0, 0, 0, 0, 0, WIN_NONE, IDLE);
    add("start",         1, 0, 0, 0, 0,  0, 0, 1, 0, 0, WIN_NONE, PLAY);
    add("play_quiet",    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, WIN_NONE, PLAY);
    add("press_noedge",  0, 1, 0, 0, 0,  1, 0, 0, 0, 0, WIN_NONE, PLAY);
    add("l_win1",        0, 1, 0, 1, 0,  1, 0, 1, 1, 0, WIN_NONE, PAUSE);
    add("pause_pr",      0, 0, 1, 0, 1,  0, 0, 0, 1, 0, WIN_NONE, PAUSE);
    add("pause_pl",      0, 1, 0, 1, 0,  0, 0, 0, 1, 0, WIN_NONE, PAUSE);
    add("pause_quiet",   0, 0, 0, 0, 0,  0, 0, 0, 1, 0, WIN_NONE, PAUSE);
    add("pause_last",    0, 0, 1, 0, 1,  0, 0, 0, 1, 0, WIN_NONE, PLAY);
    add("tie_ledge",     0, 1, 1, 1, 0,  1, 1, 0, 1, 0, WIN_NONE, PLAY);
    add("tie_both",      0, 1, 1, 1, 1,  1, 1, 0, 1, 0, WIN_NONE, PLAY);
    add("pl_redge",      0, 1, 0, 0, 1,  1, 0, 0, 1, 0, WIN_NONE, PLAY);
    add("r_win1",        0, 0, 1, 0, 1,  0, 1, 1, 1, 1, WIN_NONE, PAUSE);
    add_pause(1, 1);
    add("r_win2",        0, 0, 1, 0, 1,  0, 1, 1, 1, 2, WIN_NONE, PAUSE);
    add_pause(1, 2);
    add("r_win3",        0, 0, 1, 0, 1,  0, 1, 0, 1, 3, WIN_R,    OVER);
    add("over_rpress",   0, 0, 1, 0, 1,  0, 0, 0, 1, 3, WIN_R,    OVER);
    add("over_lpress",   0, 1, 0, 1, 0,  0, 0, 0, 1, 3, WIN_R,    OVER);
    add("over_start",    1, 0, 0, 0, 0,  0, 0, 1, 0, 0, WIN_NONE, PLAY);
    add("start_vs_win",  1, 1, 0, 1, 0,  1, 0, 1, 0, 0, WIN_NONE, PLAY);
    add("l_win_a",       0, 1, 0, 1, 0,  1, 0, 1, 1, 0, WIN_NONE, PAUSE);
    add("pause_start",   1, 0, 0, 0, 0,  0, 0, 1, 0, 0, WIN_NONE, PLAY);
    add("play_quiet2",   0, 0, 0, 0, 0,  0, 0, 0, 0, 0, WIN_NONE, PLAY);
    add("l_win_b1",      0, 1, 0, 1, 0,  1, 0, 1, 1, 0, WIN_NONE, PAUSE);
    add_pause(1, 0);
    add("l_win_b2",      0, 1, 0, 1, 0,  1, 0, 1, 2, 0, WIN_NONE, PAUSE);
    add_pause(2, 0);
    add("l_win_b3",      0, 1, 0, 1, 0,  1, 0, 0, 3, 0, WIN_L,    OVER);
    add("over_lsat",     0, 1, 0, 1, 0,  0, 0, 0, 3, 0, WIN_L,    OVER);
    add("over_start2",   1, 0, 0, 0, 0,  0, 0, 1, 0, 0, WIN_NONE, PLAY);
    add("l_win_c1",      0, 1, 0, 1, 0,  1, 0, 1, 1, 0, WIN_NONE, PAUSE);
    add_pause(1, 0);
    add("l_win_c2",      0, 1, 0, 1, 0,  1, 0, 1, 2, 0, WIN_NONE, PAUSE);
    add("pause_hold",    0, 0, 0, 0, 0,  0, 0, 0, 2, 0, WIN_NONE, PAUSE);

    repeat (2) @(negedge clk);
    chk("rst_phase",  8'(phase),     8'(IDLE));
    chk("rst_fc",     8'(field_clr), 8'h0);
    chk("rst_score",  8'({score_l, score_r}), 8'h0);
    chk("rst_winner", 8'(winner),    8'h0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      start = v.st; p_l = v.pl; p_r = v.pr; l_edge = v.le; r_edge = v.re;
      exp_q.push_back(v);
      #1;
      chk({v.name, ".l_gate"}, 8'(l_gate), 8'(v.lg));
      chk({v.name, ".r_gate"}, 8'(r_gate), 8'(v.rg));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({e.name, ".field_clr"}, 8'(field_clr), 8'(e.fc));
      chk({e.name, ".score_l"},   8'(score_l),   8'(e.sl));
      chk({e.name, ".score_r"},   8'(score_r),   8'(e.sr));
      chk({e.name, ".winner"},    8'(winner),    8'(e.win));
      chk({e.name, ".phase"},     8'(phase),     8'(e.ph));
      @(negedge clk);
    end

    // Async reset mid-PAUSE with score_l=2: outputs clear before any clock edge.
    start = 0; p_l = 1; p_r = 0; l_edge = 1; r_edge = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst.score_l", 8'(score_l),   8'h0);
    chk("arst.phase",   8'(phase),     8'(IDLE));
    chk("arst.winner",  8'(winner),    8'h0);
    chk("arst.fc",      8'(field_clr), 8'h0);
    chk("arst.l_gate",  8'(l_gate),    8'h0);
    @(negedge clk);
    rst = 1'b1; p_l = 1; p_r = 1; r_edge = 1;
    #1;
    chk("post.l_gate", 8'(l_gate), 8'h0);
    chk("post.r_gate", 8'(r_gate), 8'h0);
    @(posedge clk);
    #1;
    chk("post.phase", 8'(phase), 8'(IDLE));
    chk("post.score", 8'({score_l, score_r}), 8'h0);
    chk("post.fc",    8'(field_clr), 8'h0);
    @(negedge clk);
    p_l = 0; p_r = 0; l_edge = 0; r_edge = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tug_match_ctrl.md
# tug_match_ctrl

Match sequencer for the two-player tug-of-war game on the DE1-SoC. It sits between the two `user_in` press detectors and the `playfield`/`victory` path. It gates player presses into the playfield only while a round is live, and detects round wins from the playfield edge LEDs. It keeps per-player round scores, inserts a timed pause with field recentre between rounds, and declares a match winner at `WIN_ROUNDS`.

## Interface
- `WIN_ROUNDS`, 7 — rounds needed to win the match; range 1..7.
- `PAUSE_CYCLES`, 50_000_000 — length of the between-rounds pause in `clk` cycles (1 s at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock (CLOCK_50).
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins or restarts a match.
- `p_l`  in  1  one-cycle left press pulse from `user_in`.
- `p_r`  in  1  one-cycle right press pulse from `user_in`.
- `l_edge`  in  1  playfield leftmost LED lit (LEDR[8]).
- `r_edge`  in  1  playfield rightmost LED lit (LEDR[0]).
- `l_gate`  out  1  left press forwarded to playfield.
- `r_gate`  out  1  right press forwarded to playfield.
- `field_clr`  out  1  one-cycle synchronous recentre pulse to playfield.
- `score_l`  out  3  left rounds won.
- `score_r`  out  3  right rounds won.
- `winner`  out  2  match winner: 00 none, 10 left, 01 right.
- `phase`  out  3  current state, for display/debug.

## Operation
- States: IDLE, PLAY, PAUSE, OVER.
- **IDLE**, the reset state: presses are blocked. On `start`, go to PLAY, pulse `field_clr`, and zero the scores.
- **PLAY**: presses pass to the playfield.
  - Left round win: `l_edge & p_l & ~p_r`.
  - Right round win: `r_edge & p_r & ~p_l`.
  - Both presses in the same cycle: no point; both are still forwarded.
  - On a round win, increment the winner's score. If the new score equals `WIN_ROUNDS`, go to OVER and set `winner`. Otherwise go to PAUSE.
- **PAUSE**: presses are blocked.
  - `field_clr` pulses on the first PAUSE cycle.
  - A down-counter loaded with `PAUSE_CYCLES-1` on entry decrements each cycle.
  - At 0, go to PLAY.
- **OVER**: presses are blocked; scores and `winner` hold. On `start`, zero the scores, clear `winner`, pulse `field_clr`, and go to PLAY.
- `start` in PLAY or PAUSE aborts the match: same action as `start` in OVER. `start` has priority over a same-cycle round win.
- Scores saturate at `WIN_ROUNDS`; they can never exceed it.

## Timing
- Reset (`rst` low, async) forces: IDLE; `l_gate`=`r_gate`=`field_clr`=0; scores 0; `winner`=00; pause counter 0; `phase`=IDLE encoding.
- `l_gate`/`r_gate` are combinational: `p_x & (state==PLAY)`. They have zero latency, and are also forwarded in the cycle a win is detected.
- Scores, `winner`, `phase`, and `field_clr` are registered and update on the clock edge after the deciding input.
- `field_clr` is high for exactly one cycle:
  - the cycle after a `start` is accepted;
  - the first cycle of PAUSE.
- PAUSE lasts exactly `PAUSE_CYCLES` cycles. PLAY is entered on cycle `PAUSE_CYCLES` after the winning press.
- A press arriving on the final PAUSE cycle is blocked. The first accepted press is in the first PLAY cycle.
- `rst` asserted mid-match discards all state immediately. After release, the block waits in IDLE for `start`.

## Structure
- Package `tug_pkg` holds:
  - the `state_t` enum (IDLE, PLAY, PAUSE, OVER), which is also the `phase` encoding;
  - `WIN_NONE`/`WIN_L`/`WIN_R` 2-bit constants;
  - the score width constant (3).
- Sub-module `pause_timer`:
  - parameter `CYCLES`;
  - ports `clk`, `rst`, `load`, `done`;
  - a `$clog2(CYCLES)`-bit down-counter.
- Top-level integration:
  - `start` comes from a third `user_in` on KEY[1];
  - `field_clr` is ORed into the playfield reset path;
  - the scores drive two HEX digits.

## Test plan
Run with `WIN_ROUNDS=3`, `PAUSE_CYCLES=4`.
1. Release reset, pulse `p_l`/`p_r` in IDLE → `l_gate`/`r_gate` stay 0; `phase`=IDLE. Then `start` → next cycle `field_clr`=1 for 1 cycle and `phase`=PLAY.
2. In PLAY, hold `l_edge`=1 and pulse `p_l` → `l_gate`=1 that cycle; next cycle `score_l`=1, `field_clr`=1, `phase`=PAUSE. A `p_r` during the following 4 cycles gives `r_gate`=0. PLAY resumes 4 cycles after the press.
3. In PLAY, `l_edge`=1 with `p_l` and `p_r` in the same cycle → both gates 1, scores unchanged, stays PLAY.
4. Right wins 3 rounds → `score_r`=3, `winner`=01, `phase`=OVER. Further `r_edge`+`p_r` changes nothing. `start` → scores 0, `winner`=00, `field_clr` pulse, PLAY.
5. `start` in the same cycle as a winning `p_l` in PLAY → scores 0, `field_clr` pulse, stays PLAY (restart wins).
6. Drop `rst` asynchronously mid-PAUSE with `score_l`=2 → outputs are zero before the next clock edge. After release, `phase`=IDLE and gates stay blocked.
